// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster phase type and default 640x480@60 timing
package vga_timing_pkg;
    localparam int POS_W = 10;

    localparam int DEF_H_VIEW  = 640;
    localparam int DEF_H_FRONT = 16;
    localparam int DEF_H_SYNC  = 96;
    localparam int DEF_H_BACK  = 48;
    localparam int DEF_V_VIEW  = 480;
    localparam int DEF_V_FRONT = 10;
    localparam int DEF_V_SYNC  = 2;
    localparam int DEF_V_BACK  = 33;

    typedef enum logic [1:0] {PH_VIEW, PH_FRONT, PH_SYNC, PH_BACK} phase_t;
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis position counter with its VIEW/FRONT/SYNC/BACK phase FSM
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VIEW  = DEF_H_VIEW,
    parameter int FRONT = DEF_H_FRONT,
    parameter int SYNC  = DEF_H_SYNC,
    parameter int BACK  = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [POS_W-1:0] pos,
    output phase_t           phase,
    output logic             wrap
);
    localparam int TOTAL = VIEW + FRONT + SYNC + BACK;
    // Boundaries are one bit wider so a boundary equal to TOTAL can never alias to 0.
    localparam logic [POS_W:0] LAST   = (POS_W+1)'(TOTAL - 1);
    localparam logic [POS_W:0] B_FRNT = (POS_W+1)'(VIEW);
    localparam logic [POS_W:0] B_SYNC = (POS_W+1)'(VIEW + FRONT);
    localparam logic [POS_W:0] B_BACK = (POS_W+1)'(VIEW + FRONT + SYNC);

    if (TOTAL > (1 << POS_W)) begin : g_total_chk
        $error("vga_axis_counter: total %0d exceeds %0d", TOTAL, 1 << POS_W);
    end

    logic [POS_W-1:0] pos_nxt;
    phase_t           phase_nxt;

    assign wrap = {1'b0, pos} == LAST;

    // Next position and phase; the later boundary wins so zero-length states are skipped.
    always_comb begin
        pos_nxt   = pos;
        phase_nxt = phase;
        if (step) begin
            pos_nxt   = wrap ? '0 : pos + 1'b1;
            phase_nxt = ({1'b0, pos_nxt} == B_BACK) ? PH_BACK  :
                        ({1'b0, pos_nxt} == B_SYNC) ? PH_SYNC  :
                        ({1'b0, pos_nxt} == B_FRNT) ? PH_FRONT :
                        (pos_nxt == '0)             ? PH_VIEW  : phase;
        end
    end

    // Position and phase state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos   <= '0;
            phase <= PH_VIEW;
        end else begin
            pos   <= pos_nxt;
            phase <= phase_nxt;
        end
    end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing with sync, blanking, position and line/frame strobes
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VIEW   = DEF_H_VIEW,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   V_VIEW   = DEF_V_VIEW,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    output logic [POS_W-1:0] hpos,
    output logic [POS_W-1:0] vpos,
    output logic             hsync,
    output logic             vsync,
    output logic             visible,
    output logic             hblank,
    output logic             vblank,
    output logic             line_tick,
    output logic             frame_tick,
    output logic [7:0]       frame_count
);
    phase_t h_phase;
    phase_t v_phase;
    logic   h_wrap;
    logic   v_wrap;

    vga_axis_counter #(.VIEW(H_VIEW), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)) u_h (
        .clk  (clk),
        .rst_n(rst_n),
        .step (ena),
        .pos  (hpos),
        .phase(h_phase),
        .wrap (h_wrap)
    );

    vga_axis_counter #(.VIEW(V_VIEW), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)) u_v (
        .clk  (clk),
        .rst_n(rst_n),
        .step (ena & h_wrap),
        .pos  (vpos),
        .phase(v_phase),
        .wrap (v_wrap)
    );

    // Strobes land in the cycle the counters show the wrapped position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_tick   <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            line_tick  <= ena & h_wrap;
            frame_tick <= ena & h_wrap & v_wrap;
            if (ena && h_wrap && v_wrap) frame_count <= frame_count + 1'b1;
        end
    end

    assign hsync   = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vsync   = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign hblank  = h_phase != PH_VIEW;
    assign vblank  = v_phase != PH_VIEW;
    assign visible = !hblank && !vblank;
endmodule
